mxv_tx_scheduler: RTL and testbench
===================================

# mxv_tx_scheduler

Arbitrates the shared UART transmitter between two requesters of the matrix-vector (mxv) unit: the result path (new result vector ready) and the resend path (host resend command decoded). It frames each response as FE, L, CMD, N payload bytes, EF. Payload bytes are read from the synchronous result RAM. Each byte is handed to the UART TX core with a start/done handshake.

## Interface
- DATA_W, 8, UART byte width
- MAX_N, 8, maximum vector length
- ADDR_W, 3, result RAM address width (clog2(MAX_N))

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_result  in  1  one-cycle pulse: result vector ready
- req_resend  in  1  one-cycle pulse: resend of last vector requested
- n_size  in  4  vector length, sampled at grant
- rd_addr  out  ADDR_W  result RAM read address
- rd_data  in  DATA_W  RAM data, valid 1 cycle after rd_addr
- tx_data  out  DATA_W  byte to UART TX
- tx_start  out  1  one-cycle pulse: start sending tx_data
- tx_done  in  1  one-cycle pulse: UART finished current byte
- gnt_result  out  1  one-cycle pulse: result frame granted
- gnt_resend  out  1  one-cycle pulse: resend frame granted
- busy  out  1  high from grant until frame_done
- frame_done  out  1  one-cycle pulse after EF byte completes

## Operation
- Pending flags pend_result and pend_resend are set by their req pulses.
- A flag clears when its frame is granted. If set and clear hit the same cycle, set wins and the request stays queued.
- Arbitration happens in IDLE only and is round-robin.
  - A lone pending request wins.
  - On a tie, the requester not granted last wins.
  - last_grant resets to "result", so the first tie goes to resend.
- At grant, the block latches n_lat = n_size.
  - n_size > MAX_N clamps to MAX_N.
  - n_size = 0 sends a frame with no payload.
- Frame bytes, in order:
  - 8'hFE
  - L = n_lat+1
  - CMD: 8'h04 for result, 8'h05 for resend
  - payload RAM[0..n_lat-1]
  - 8'hEF
- FSM states: IDLE, GRANT, LOAD, FETCH, START, WAIT, DONE.
  - IDLE -> GRANT when any flag is pending.
  - GRANT -> LOAD.
  - LOAD -> START for header and EF bytes.
  - LOAD -> FETCH for payload bytes. FETCH drives rd_addr = idx, then goes to START with tx_data = rd_data.
  - START -> WAIT.
  - WAIT -> LOAD on tx_done, with byte index +1. After EF: WAIT -> DONE on tx_done.
  - DONE -> IDLE.
- tx_data holds stable from START until tx_done. tx_done outside WAIT is ignored.
- rd_addr holds its last value outside FETCH.
- Async reset mid-frame aborts immediately: all outputs 0, flags cleared, state IDLE. No partial frame resumes.

## Timing
- Reset values: tx_start=0, tx_data=0, rd_addr=0, gnt_*=0, busy=0, frame_done=0, last_grant=result.
- Sequence after a req pulse in cycle t:
  - flag set at t+1
  - GRANT at t+2: gnt_* pulses, busy rises
  - tx_start for FE at t+4
- Header/EF bytes: tx_start 2 cycles after the previous byte's tx_done (LOAD, START).
- Payload bytes: tx_start 3 cycles after the previous byte's tx_done (LOAD, FETCH, START).
- frame_done pulses in DONE, 1 cycle after the EF tx_done; busy falls in the same cycle.
- A queued request is granted 2 cycles after frame_done (IDLE, GRANT).
- Frame length: n_lat+4 bytes, or n_lat+5 with checksum enabled.

## Configuration
- MXV_TX_CHECKSUM_EN defined:
  - A checksum byte (XOR of CMD and all payload bytes) is inserted between the last payload byte and EF.
  - L = n_lat+2.
- Undefined: no checksum byte; L = n_lat+1; the checksum logic is absent.

## Test plan
- Result frame: req_result with n_size=3, RAM={11,22,33}, tx_done 5 cycles after each tx_start -> bytes FE,04,04,11,22,33,EF; single frame_done; gnt_result pulsed once. With checksum enabled: FE,05,04,11,22,33,04,EF (checksum 04^11^22^33=04).
- Tie: req_result and req_resend pulsed in the same cycle after reset -> resend frame first (CMD 05), then result frame (CMD 04) 2 cycles after frame_done.
- Re-request during own frame: req_result pulsed mid-frame -> a second result frame follows, and no request is lost.
- Clamp/empty: n_size=12 -> 8 payload bytes, L=09; n_size=0 -> FE,01,CMD,EF.
- Handshake: tx_done pulses in GRANT or LOAD are ignored; tx_data stays stable until tx_done even with a 100-cycle delay.
- Reset mid-payload: rst low during byte 2 -> outputs 0 immediately; after release, IDLE with no pending flags and no tx_start.

Source files
------------

// File: rtl/mxv_tx_scheduler.sv
// Shared UART TX scheduler for the mxv unit: round-robin between result and resend requesters,
// framing FE, L, CMD, payload, EF. Define MXV_TX_CHECKSUM_EN to insert an XOR checksum byte.
module mxv_tx_scheduler #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_result,
  input  logic              i_req_resend,
  input  logic [3:0]        i_n_size,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_start,
  input  logic              i_tx_done,
  output logic              o_gnt_result,
  output logic              o_gnt_resend,
  output logic              o_busy,
  output logic              o_frame_done
);

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StLoad,
    StFetch,
    StStart,
    StWait,
    StDone
  } state_e;

  localparam logic [DATA_W-1:0] SOF        = DATA_W'(8'hFE);
  localparam logic [DATA_W-1:0] EOF        = DATA_W'(8'hEF);
  localparam logic [DATA_W-1:0] CMD_RESULT = DATA_W'(8'h04);
  localparam logic [DATA_W-1:0] CMD_RESEND = DATA_W'(8'h05);
  localparam logic [3:0]        N_MAX      = 4'(MAX_N);
`ifdef MXV_TX_CHECKSUM_EN
  localparam logic [4:0]        LAST_OFF   = 5'd4;
  localparam logic [DATA_W-1:0] LEN_OFF    = DATA_W'(2);
`else
  localparam logic [4:0]        LAST_OFF   = 5'd3;
  localparam logic [DATA_W-1:0] LEN_OFF    = DATA_W'(1);
`endif

  state_e              r_state;
  state_e              w_state_d;
  logic                r_pend_result;
  logic                r_pend_resend;
  logic                r_last_grant;  // 0: result, 1: resend
  logic                r_cur;         // frame in flight, same encoding
  logic [3:0]          r_n_lat;
  logic [4:0]          r_idx;
  logic [DATA_W-1:0]   r_tx_data;
  logic [ADDR_W-1:0]   r_rd_addr;

  logic                w_pick_resend;
  logic                w_clr_result;
  logic                w_clr_resend;
  logic [3:0]          w_n_clamp;
  logic [4:0]          w_last_idx;
  logic                w_is_pay;
  logic [DATA_W-1:0]   w_cmd;
  logic [DATA_W-1:0]   w_len;
  logic [DATA_W-1:0]   w_hdr_byte;

  // Tie goes to whichever side was not granted last.
  assign w_pick_resend = r_pend_resend & (~r_pend_result | ~r_last_grant);
  assign w_clr_result  = (r_state == StGrant) & ~r_cur;
  assign w_clr_resend  = (r_state == StGrant) & r_cur;
  assign w_n_clamp     = (i_n_size > N_MAX) ? N_MAX : i_n_size;
  assign w_last_idx    = 5'(r_n_lat) + LAST_OFF;
  assign w_is_pay      = (r_idx >= 5'd3) && (r_idx < 5'(r_n_lat) + 5'd3);
  assign w_cmd         = r_cur ? CMD_RESEND : CMD_RESULT;
  assign w_len         = DATA_W'(r_n_lat) + LEN_OFF;

`ifdef MXV_TX_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= '0;
    end else if (r_state == StGrant) begin
      r_csum <= w_cmd;
    end else if (r_state == StStart && w_is_pay) begin
      r_csum <= r_csum ^ i_rd_data;
    end
  end
`endif

  always_comb begin
    w_hdr_byte = EOF;
    if (r_idx == 5'd0) begin
      w_hdr_byte = SOF;
    end else if (r_idx == 5'd1) begin
      w_hdr_byte = w_len;
    end else if (r_idx == 5'd2) begin
      w_hdr_byte = w_cmd;
`ifdef MXV_TX_CHECKSUM_EN
    end else if (r_idx == w_last_idx - 5'd1) begin
      w_hdr_byte = r_csum;
`endif
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (r_pend_result || r_pend_resend) w_state_d = StGrant;
      StGrant: w_state_d = StLoad;
      StLoad:  w_state_d = w_is_pay ? StFetch : StStart;
      StFetch: w_state_d = StStart;
      StStart: w_state_d = StWait;
      StWait:  if (i_tx_done) w_state_d = (r_idx == w_last_idx) ? StDone : StLoad;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_pend_result <= 1'b0;
      r_pend_resend <= 1'b0;
      r_last_grant  <= 1'b0;
      r_cur         <= 1'b0;
      r_n_lat       <= '0;
      r_idx         <= '0;
      r_tx_data     <= '0;
      r_rd_addr     <= '0;
    end else begin
      r_state       <= w_state_d;
      // A request arriving in the grant cycle stays queued.
      r_pend_result <= i_req_result | (r_pend_result & ~w_clr_result);
      r_pend_resend <= i_req_resend | (r_pend_resend & ~w_clr_resend);
      case (r_state)
        StIdle: r_cur <= w_pick_resend;
        StGrant: begin
          r_last_grant <= r_cur;
          r_n_lat      <= w_n_clamp;
          r_idx        <= '0;
        end
        StLoad: begin
          if (w_is_pay) r_rd_addr <= ADDR_W'(r_idx - 5'd3);
          else          r_tx_data <= w_hdr_byte;
        end
        StStart: if (w_is_pay) r_tx_data <= i_rd_data;
        StWait:  if (i_tx_done && r_idx != w_last_idx) r_idx <= r_idx + 5'd1;
        default: ;
      endcase
    end
  end

  // RAM data arrives in START; bypass it so tx_data is valid alongside tx_start.
  assign o_tx_data    = (r_state == StStart && w_is_pay) ? i_rd_data : r_tx_data;
  assign o_rd_addr    = r_rd_addr;
  assign o_tx_start   = (r_state == StStart);
  assign o_gnt_result = (r_state == StGrant) & ~r_cur;
  assign o_gnt_resend = (r_state == StGrant) & r_cur;
  assign o_busy       = (r_state != StIdle) && (r_state != StDone);
  assign o_frame_done = (r_state == StDone);

endmodule

// File: tb/tb_mxv_tx_scheduler.sv
// Randomised bench for mxv_tx_scheduler: frame-level reference model checked every cycle,
// plus literal frame expectations from the test plan.
module tb_mxv_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_result = 1'b0;
  logic       req_resend = 1'b0;
  logic       tx_done = 1'b0;
  logic [3:0] n_size = 4'd0;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_data;
  logic       tx_start, gnt_result, gnt_resend, busy, frame_done;
  logic [7:0] ram [8];

  always #5 clk = ~clk;

  mxv_tx_scheduler #(.DATA_W(8), .MAX_N(8), .ADDR_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_result (req_result),
    .i_req_resend (req_resend),
    .i_n_size     (n_size),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .i_tx_done    (tx_done),
    .o_gnt_result (gnt_result),
    .o_gnt_resend (gnt_resend),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  always @(posedge clk) rd_data <= ram[rd_addr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending flags, arbitration and the expected byte list of the frame.
  typedef enum int {MIdle, MBusy, MDone} mmode_e;
  mmode_e     m_mode = MIdle;
  logic       m_pend_res = 0, m_pend_rsd = 0, m_last = 0, m_win = 0, m_gnt_now = 0, m_wait = 0;
  logic       nxt_gnt, e_start;
  int         m_next = 0, m_pos = 0, m_len = 0, cyc = 0;
  logic [7:0] m_byte [16];
  logic       m_pay [16];
  int         m_addr [16];

  int         n_gnt_res = 0, n_gnt_rsd = 0, n_fdone = 0, last_fdone_cyc = 0, last_gnt_cyc = 0;
  logic [7:0] obs_q [$];
  logic [7:0] lit_q [$];

  task automatic build_frame();
    int n, k;
    logic [7:0] cs;
    n = (n_size > 4'd8) ? 8 : int'(n_size);
    for (int i = 0; i < 16; i++) m_pay[i] = 1'b0;
    cs = m_win ? 8'h05 : 8'h04;
    m_byte[0] = 8'hFE;
`ifdef MXV_TX_CHECKSUM_EN
    m_byte[1] = 8'(n + 2);
`else
    m_byte[1] = 8'(n + 1);
`endif
    m_byte[2] = cs;
    k = 3;
    for (int i = 0; i < n; i++) begin
      m_byte[k] = ram[i];
      m_pay[k]  = 1'b1;
      m_addr[k] = i;
      cs        = cs ^ ram[i];
      k++;
    end
`ifdef MXV_TX_CHECKSUM_EN
    m_byte[k] = cs;
    k++;
`endif
    m_byte[k] = 8'hEF;
    m_len     = k + 1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_mode = MIdle; m_pend_res = 0; m_pend_rsd = 0; m_last = 0; m_win = 0;
      m_gnt_now = 0; m_wait = 0; m_next = 0; m_pos = 0; m_len = 0;
    end else begin
      cyc++;
      e_start = (m_mode == MBusy) && !m_wait && (cyc == m_next);
      chk("gnt_result", 32'(gnt_result), 32'(m_gnt_now && !m_win));
      chk("gnt_resend", 32'(gnt_resend), 32'(m_gnt_now && m_win));
      chk("busy", 32'(busy), 32'(m_mode == MBusy));
      chk("frame_done", 32'(frame_done), 32'(m_mode == MDone));
      chk("tx_start", 32'(tx_start), 32'(e_start));
      if (m_mode == MBusy && (e_start || m_wait)) chk("tx_data", 32'(tx_data), 32'(m_byte[m_pos]));
      if (e_start && m_pay[m_pos]) chk("rd_addr", 32'(rd_addr), 32'(m_addr[m_pos]));

      if (tx_start) obs_q.push_back(tx_data);
      if (gnt_result) begin n_gnt_res++; last_gnt_cyc = cyc; end
      if (gnt_resend) begin n_gnt_rsd++; last_gnt_cyc = cyc; end
      if (frame_done) begin n_fdone++; last_fdone_cyc = cyc; end

      nxt_gnt = 1'b0;
      if (m_gnt_now) begin
        build_frame();
        m_next = cyc + 2;
        m_pos  = 0;
        m_wait = 0;
        m_last = m_win;
      end
      case (m_mode)
        MIdle: if (m_pend_res || m_pend_rsd) begin
          m_win   = (m_pend_res && m_pend_rsd) ? !m_last : m_pend_rsd;
          m_mode  = MBusy;
          nxt_gnt = 1'b1;
        end
        MBusy: if (e_start) begin
          m_wait = 1'b1;
        end else if (m_wait && tx_done) begin
          m_wait = 1'b0;
          if (m_pos == m_len - 1) m_mode = MDone;
          else begin
            m_pos++;
            m_next = cyc + (m_pay[m_pos] ? 3 : 2);
          end
        end
        default: m_mode = MIdle;
      endcase
      if (m_gnt_now) begin
        if (m_win) m_pend_rsd = 1'b0;
        else       m_pend_res = 1'b0;
      end
      if (req_result) m_pend_res = 1'b1;
      if (req_resend) m_pend_rsd = 1'b1;
      m_gnt_now = nxt_gnt;
    end
  end

  // UART stand-in: tx_done a fixed or random number of cycles after tx_start, plus optional
  // stray pulses in the GRANT and LOAD cycles.
  int dly = 5;
  bit rand_dly = 0, spur_en = 0, spur_nxt = 0;
  int resp_cnt = 0;

  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (!rst) begin
      resp_cnt = 0;
      spur_nxt = 0;
    end else begin
      if (spur_nxt) tx_done = 1'b1;
      spur_nxt = 0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) tx_done = 1'b1;
      end
      if (tx_start) resp_cnt = rand_dly ? int'($urandom_range(1, 6)) : dly;
      if (spur_en && (gnt_result || gnt_resend)) begin
        tx_done  = 1'b1;
        spur_nxt = 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_fdone(input int cnt, input int budget);
    int target;
    int k;
    target = n_fdone + cnt;
    k = 0;
    while (n_fdone < target && k < budget) begin
      step(1);
      k++;
    end
    if (n_fdone < target) chk("timeout_frame_done", 32'(n_fdone), 32'(target));
  endtask

  task automatic wait_obs(input int cnt, input int budget);
    int k;
    k = 0;
    while (obs_q.size() < cnt && k < budget) begin
      step(1);
      k++;
    end
    if (obs_q.size() < cnt) chk("timeout_tx_start", 32'(obs_q.size()), 32'(cnt));
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, 32'(obs_q.size()), 32'(lit_q.size()));
    for (int i = 0; i < lit_q.size() && i < obs_q.size(); i++) chk(nm, 32'(obs_q[i]), 32'(lit_q[i]));
    obs_q.delete();
  endtask

  int f1, g0, s0;

  initial begin
    ram[0] = 8'h11; ram[1] = 8'h22; ram[2] = 8'h33; ram[3] = 8'h44;
    ram[4] = 8'h55; ram[5] = 8'h66; ram[6] = 8'h77; ram[7] = 8'h88;
    step(2);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'({gnt_result, gnt_resend}), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    rst = 1'b1;
    step(3);

    // Tie straight after reset: resend first, then result.
    n_size = 4'd3;
    req_result = 1'b1; req_resend = 1'b1;
    step(1);
    req_result = 1'b0; req_resend = 1'b0;
    wait_fdone(1, 500);
    f1 = last_fdone_cyc;
    wait_fdone(1, 500);
    chk("tie_gap", 32'(last_gnt_cyc - f1), 2);
`ifdef MXV_TX_CHECKSUM_EN
    lit_q = '{8'hFE, 8'h05, 8'h05, 8'h11, 8'h22, 8'h33, 8'h05, 8'hEF,
              8'hFE, 8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h04, 8'hEF};
`else
    lit_q = '{8'hFE, 8'h04, 8'h05, 8'h11, 8'h22, 8'h33, 8'hEF,
              8'hFE, 8'h04, 8'h04, 8'h11, 8'h22, 8'h33, 8'hEF};
`endif
    check_log("tie_bytes");

    // Single result frame.
    g0 = n_gnt_res;
    s0 = n_fdone;
    step(2);
    req_result = 1'b1;
    step(1);
    req_result = 1'b0;
    wait_fdone(1, 500);
`ifdef MXV_TX_CHECKSUM_EN
    lit_q = '{8'hFE, 8'h05, 8'h04, 8'h11, 8'h22, 8'h33, 8'h04, 8'hEF};
`else
    lit_q = '{8'hFE, 8'h04, 8'h04, 8'h11, 8'h22, 8'h33, 8'hEF};
`endif
    check_log("result_bytes");
    step(3);
    chk("result_gnt_count", 32'(n_gnt_res - g0), 1);
    chk("result_fdone_count", 32'(n_fdone - s0), 1);

    // Re-request during own frame.
    g0 = n_gnt_res;
    req_result = 1'b1;
    step(1);
    req_result = 1'b0;
    wait_obs(2, 100);
    req_result = 1'b1;
    step(1);
    req_result = 1'b0;
    wait_fdone(2, 1000);
    step(5);
    chk("rereq_gnt_count", 32'(n_gnt_res - g0), 2);
`ifdef MXV_TX_CHECKSUM_EN
    chk("rereq_bytes", 32'(obs_q.size()), 16);
`else
    chk("rereq_bytes", 32'(obs_q.size()), 14);
`endif
    obs_q.delete();

    // Clamp and empty frames.
    n_size = 4'd12;
    req_result = 1'b1;
    step(1);
    req_result = 1'b0;
    wait_fdone(1, 1000);
`ifdef MXV_TX_CHECKSUM_EN
    chk("clamp_len", 32'(obs_q.size()), 13);
    if (obs_q.size() > 1) chk("clamp_L", 32'(obs_q[1]), 32'h0A);
`else
    chk("clamp_len", 32'(obs_q.size()), 12);
    if (obs_q.size() > 1) chk("clamp_L", 32'(obs_q[1]), 32'h09);
`endif
    obs_q.delete();
    step(2);
    n_size = 4'd0;
    req_resend = 1'b1;
    step(1);
    req_resend = 1'b0;
    wait_fdone(1, 500);
`ifdef MXV_TX_CHECKSUM_EN
    lit_q = '{8'hFE, 8'h02, 8'h05, 8'h05, 8'hEF};
`else
    lit_q = '{8'hFE, 8'h01, 8'h05, 8'hEF};
`endif
    check_log("empty_bytes");

    // Stray tx_done in GRANT/LOAD and a 100-cycle UART.
    step(2);
    spur_en = 1; dly = 100; n_size = 4'd1;
    req_resend = 1'b1;
    step(1);
    req_resend = 1'b0;
    wait_fdone(1, 1000);
`ifdef MXV_TX_CHECKSUM_EN
    lit_q = '{8'hFE, 8'h03, 8'h05, 8'h11, 8'h14, 8'hEF};
`else
    lit_q = '{8'hFE, 8'h02, 8'h05, 8'h11, 8'hEF};
`endif
    check_log("slow_bytes");
    spur_en = 0; dly = 5;

    // Random traffic against the model.
    step(2);
    for (int i = 0; i < 8; i++) ram[i] = 8'($urandom);
    rand_dly = 1;
    s0 = n_fdone;
    for (int i = 0; i < 4000; i++) begin
      req_result = ($urandom_range(0, 23) == 0);
      req_resend = ($urandom_range(0, 23) == 0);
      n_size     = 4'($urandom_range(0, 15));
      spur_en    = ((i / 500) % 2 == 1);
      step(1);
    end
    req_result = 1'b0; req_resend = 1'b0; spur_en = 0;
    step(400);
    chk("rand_frames_seen", 32'(n_fdone > s0 + 10), 1);
    obs_q.delete();

    // Reset during the second payload byte, with a resend queued.
    rand_dly = 0; dly = 8; n_size = 4'd5;
    req_result = 1'b1;
    step(1);
    req_result = 1'b0;
    wait_obs(5, 200);
    req_resend = 1'b1;
    step(1);
    req_resend = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("abort_tx_start", 32'(tx_start), 0);
    chk("abort_tx_data", 32'(tx_data), 0);
    chk("abort_rd_addr", 32'(rd_addr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_gnt", 32'({gnt_result, gnt_resend}), 0);
    chk("abort_frame_done", 32'(frame_done), 0);
    step(3);
    rst = 1'b1;
    obs_q.delete();
    g0 = n_gnt_res + n_gnt_rsd;
    step(40);
    chk("post_rst_starts", 32'(obs_q.size()), 0);
    chk("post_rst_grants", 32'(n_gnt_res + n_gnt_rsd), 32'(g0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
